// File: rtl/circle_plot_gen.sv
// Pixel generator for a small framebuffer: clears the screen or rasterises a
// midpoint circle outline / filled disc, presenting one candidate pixel per cycle.
module circle_plot_gen #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [X_W-1:0]      radius,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);
    localparam int SW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int CW = SW + 2;

    typedef enum logic [2:0] {IDLE, CLEAR, ARC, SPAN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [COLOUR_W-1:0]   col_reg, col_next;
    logic signed [SW-1:0]  cx_reg, cx_next, cy_reg, cy_next;
    logic signed [SW-1:0]  ox_reg, ox_next, oy_reg, oy_next, sx_reg, sx_next;
    logic signed [CW-1:0]  crit_reg, crit_next;
    logic [2:0]            k_reg, k_next;
    logic [1:0]            sidx_reg, sidx_next;
    logic [X_W-1:0]        clr_x_reg, clr_x_next;
    logic [Y_W-1:0]        clr_y_reg, clr_y_next;

    logic signed [SW-1:0]  it_oy, it_ox, span_end, cand_x, cand_y;
    logic signed [CW-1:0]  it_crit;
    logic                  it_more, crit_pos, busy_next, plot_next;

    // One midpoint step applied to the current (ox, oy, crit).
    always_comb begin
        crit_pos = !crit_reg[CW-1] && (crit_reg != '0);
        it_oy    = oy_reg + SW'(1);
        it_ox    = crit_pos ? (ox_reg - SW'(1)) : ox_reg;
        if (crit_pos)
            it_crit = crit_reg + (CW'(it_oy - it_ox) <<< 1) + CW'(1);
        else
            it_crit = crit_reg + (CW'(it_oy) <<< 1) + CW'(1);
        it_more  = (it_oy <= it_ox);
        span_end = sidx_reg[1] ? (cx_reg + oy_reg) : (cx_reg + ox_reg);
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        ox_next    = ox_reg;
        oy_next    = oy_reg;
        sx_next    = sx_reg;
        crit_next  = crit_reg;
        k_next     = k_reg;
        sidx_next  = sidx_reg;
        clr_x_next = clr_x_reg;
        clr_y_next = clr_y_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    col_next   = colour;
                    cx_next    = SW'(centre_x);
                    cy_next    = SW'(centre_y);
                    ox_next    = SW'(radius);
                    oy_next    = '0;
                    crit_next  = CW'(1) - CW'(radius);
                    k_next     = '0;
                    sidx_next  = '0;
                    sx_next    = SW'(centre_x) - SW'(radius);
                    clr_x_next = '0;
                    clr_y_next = '0;
                    case (mode)
                        2'b00:   state_next = CLEAR;
                        2'b01:   state_next = ARC;
                        2'b10:   state_next = SPAN;
                        default: state_next = DONE;
                    endcase
                end
            end
            CLEAR: begin
                if (clr_y_reg == Y_W'(SCREEN_H - 1)) begin
                    clr_y_next = '0;
                    if (clr_x_reg == X_W'(SCREEN_W - 1))
                        state_next = DONE;
                    else
                        clr_x_next = clr_x_reg + 1'b1;
                end else begin
                    clr_y_next = clr_y_reg + 1'b1;
                end
            end
            ARC: begin
                if (k_reg != 3'd7) begin
                    k_next = k_reg + 3'd1;
                end else begin
                    k_next    = '0;
                    ox_next   = it_ox;
                    oy_next   = it_oy;
                    crit_next = it_crit;
                    if (!it_more) state_next = DONE;
                end
            end
            SPAN: begin
                if (sx_reg < span_end) begin
                    sx_next = sx_reg + SW'(1);
                end else if (sidx_reg != 2'd3) begin
                    // Spans 0/1 are ox wide, spans 2/3 are oy wide.
                    sidx_next = sidx_reg + 2'd1;
                    sx_next   = (sidx_reg == 2'd0) ? (cx_reg - ox_reg) : (cx_reg - oy_reg);
                end else begin
                    sidx_next = '0;
                    ox_next   = it_ox;
                    oy_next   = it_oy;
                    crit_next = it_crit;
                    sx_next   = cx_reg - it_ox;
                    if (!it_more) state_next = DONE;
                end
            end
            DONE: begin
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Candidate for the cursor being loaded, so the pixel appears the cycle after.
    always_comb begin
        cand_x = '0;
        cand_y = '0;
        case (state_next)
            CLEAR: begin
                cand_x = SW'(clr_x_next);
                cand_y = SW'(clr_y_next);
            end
            ARC: begin
                case (k_next)
                    3'd0: begin cand_x = cx_next + ox_next; cand_y = cy_next + oy_next; end
                    3'd1: begin cand_x = cx_next + oy_next; cand_y = cy_next + ox_next; end
                    3'd2: begin cand_x = cx_next - ox_next; cand_y = cy_next + oy_next; end
                    3'd3: begin cand_x = cx_next - oy_next; cand_y = cy_next + ox_next; end
                    3'd4: begin cand_x = cx_next - ox_next; cand_y = cy_next - oy_next; end
                    3'd5: begin cand_x = cx_next - oy_next; cand_y = cy_next - ox_next; end
                    3'd6: begin cand_x = cx_next + ox_next; cand_y = cy_next - oy_next; end
                    default: begin cand_x = cx_next + oy_next; cand_y = cy_next - ox_next; end
                endcase
            end
            SPAN: begin
                cand_x = sx_next;
                case (sidx_next)
                    2'd0:    cand_y = cy_next + oy_next;
                    2'd1:    cand_y = cy_next - oy_next;
                    2'd2:    cand_y = cy_next + ox_next;
                    default: cand_y = cy_next - ox_next;
                endcase
            end
            default: ;
        endcase
        busy_next = (state_next == CLEAR) || (state_next == ARC) || (state_next == SPAN);
        plot_next = busy_next && !cand_x[SW-1] && !cand_y[SW-1] &&
                    (cand_x < SW'(SCREEN_W)) && (cand_y < SW'(SCREEN_H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            ox_reg     <= '0;
            oy_reg     <= '0;
            sx_reg     <= '0;
            crit_reg   <= '0;
            k_reg      <= '0;
            sidx_reg   <= '0;
            clr_x_reg  <= '0;
            clr_y_reg  <= '0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            ox_reg     <= ox_next;
            oy_reg     <= oy_next;
            sx_reg     <= sx_next;
            crit_reg   <= crit_next;
            k_reg      <= k_next;
            sidx_reg   <= sidx_next;
            clr_x_reg  <= clr_x_next;
            clr_y_reg  <= clr_y_next;
            done       <= (state_next == DONE);
            vga_plot   <= plot_next;
            vga_x      <= cand_x[X_W-1:0];
            vga_y      <= cand_y[Y_W-1:0];
            vga_colour <= plot_next ? col_next : '0;
        end
    end
endmodule

// File: tb/tb_circle_plot_gen.sv
// Bench for circle_plot_gen: directed vector table, reset/handshake sequences and
// random circles/discs compared against a pixel-set model of the drawing rules.
module tb_circle_plot_gen;
    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [2:0] colour = '0;
    logic [7:0] centre_x = '0;
    logic [6:0] centre_y = '0;
    logic [7:0] radius = '0;
    logic       done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int failures = 0;

    bit seen    [0:W-1][0:H-1];
    bit exp_map [0:W-1][0:H-1];

    typedef struct {
        logic [1:0] mode;
        logic [2:0] colour;
        int         cx, cy, r;
        int         exp_n;
        bit         drop;
    } vec_t;
    vec_t vecs[7];

    circle_plot_gen dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    task automatic mark(input int x, input int y);
        if (x >= 0 && x < W && y >= 0 && y < H) exp_map[x][y] = 1'b1;
    endtask

    // Reference: expected pixel set and number of candidate cycles.
    task automatic model(input int m, input int cx, input int cy, input int r, output int n);
        int ox, oy, crit;
        n = 0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                exp_map[x][y] = (m == 0);
        if (m == 0) n = W * H;
        if (m == 1 || m == 2) begin
            ox = r; oy = 0; crit = 1 - r;
            while (oy <= ox) begin
                if (m == 1) begin
                    mark(cx + ox, cy + oy); mark(cx + oy, cy + ox);
                    mark(cx - ox, cy + oy); mark(cx - oy, cy + ox);
                    mark(cx - ox, cy - oy); mark(cx - oy, cy - ox);
                    mark(cx + ox, cy - oy); mark(cx + oy, cy - ox);
                    n += 8;
                end else begin
                    for (int x = cx - ox; x <= cx + ox; x++) begin mark(x, cy + oy); mark(x, cy - oy); end
                    for (int x = cx - oy; x <= cx + oy; x++) begin mark(x, cy + ox); mark(x, cy - ox); end
                    n += 2 * (2 * ox + 1) + 2 * (2 * oy + 1);
                end
                oy++;
                if (crit <= 0) crit += 2 * oy + 1;
                else begin ox--; crit += 2 * (oy - ox) + 1; end
            end
        end
    endtask

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic run_op(input logic [1:0] m, input logic [2:0] col, input int cx, input int cy,
                          input int r, input int exp_n, input bit drop);
        int n, plots, bad_col, bad_rng, far, diff, model_n, want;
        model(m, cx, cy, r, model_n);
        want = (exp_n < 0) ? model_n : exp_n;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                seen[x][y] = 1'b0;
        mode = m; colour = col; centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
        start = 1'b1;
        @(posedge clk);
        n = 0; plots = 0; bad_col = 0; bad_rng = 0; far = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (vga_plot) begin
                plots++;
                if (vga_colour !== col) bad_col++;
                if (vga_x >= W || vga_y >= H) bad_rng++;
                else begin
                    seen[vga_x][vga_y] = 1'b1;
                    if ((int'(vga_x) - cx) ** 2 + (int'(vga_y) - cy) ** 2 > (r + 1) ** 2) far++;
                end
            end
            if (drop && n == 1) start = 1'b0;
            mode = 2'($urandom); colour = 3'($urandom);
            centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
            if (n > 40000) begin
                check("op_timeout", n, want);
                break;
            end
        end
        diff = 0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                if (seen[x][y] != exp_map[x][y]) diff++;
        $display("op mode=%0d centre=(%0d,%0d) r=%0d cycles=%0d plots=%0d set_diff=%0d",
                 m, cx, cy, r, n, plots, diff);
        check("cycles", n, want);
        check("pixel_set_diff", diff, 0);
        check("plot_colour_errors", bad_col, 0);
        check("plot_out_of_range", bad_rng, 0);
        if (m == 0) check("clear_plot_count", plots, W * H);
        if (m == 2) check("disc_far_pixels", far, 0);
        if (start) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("done_hold", {done, vga_plot}, 2'b10);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_release", {done, vga_plot}, 2'b00);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{2'b00, 3'b101, 0,   0,   0,  19200, 1'b0};
        vecs[1] = '{2'b01, 3'b011, 80,  60,  0,  8,     1'b0};
        vecs[2] = '{2'b01, 3'b110, 0,   0,   10, 64,    1'b1};
        vecs[3] = '{2'b10, 3'b010, 80,  60,  5,  116,   1'b0};
        vecs[4] = '{2'b11, 3'b111, 80,  60,  9,  0,     1'b0};
        vecs[5] = '{2'b10, 3'b001, 0,   0,   0,  4,     1'b0};
        vecs[6] = '{2'b01, 3'b100, 159, 119, 0,  8,     1'b1};

        repeat (2) @(negedge clk);
        check("reset_outputs", int'({done, vga_plot, vga_x, vga_y, vga_colour}), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || vga_plot) cnt++;
        end
        check("idle_without_start", cnt, 0);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].mode, vecs[i].colour, vecs[i].cx, vecs[i].cy, vecs[i].r,
                   vecs[i].exp_n, vecs[i].drop);

        // Reset in the middle of a screen clear, then a reserved-mode request.
        mode = 2'b00; colour = 3'b110; start = 1'b1;
        @(posedge clk);
        repeat (500) @(negedge clk);
        check("clear_running_before_reset", int'(vga_plot), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_clear_reset", int'({done, vga_plot, vga_x, vga_y, vga_colour}), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_op(2'b11, 3'b001, 10, 10, 3, 0, 1'b0);

        run_op(2'b01, 3'b011, 200, 100, 255, -1, 1'b0);
        for (int i = 0; i < 12; i++)
            run_op(2'(1 + $urandom_range(0, 2)), 3'($urandom_range(1, 7)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 40)), -1, 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
